// File: rtl/mem_range_stream_reader_if.sv
// Bundle for mem_range_stream_reader: read request port toward memory plus the
// in-order output stream. Macro-independent.
//   master : the reader (drives mem_req_o/mem_addr_o and the stream outputs)
//   slave  : memory + stream consumer
// Ports:
//   mem_req_o/mem_addr_o           read request, held until mem_gnt_i
//   mem_gnt_i                      request accepted this cycle
//   mem_rvalid_i/rdata/err         in-order response, err qualified by rvalid
//   out_valid_o/out_ready_i        stream handshake
//   out_data_o/out_addr_o/last     element payload
interface mem_range_stream_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_err_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [ADDR_W-1:0] out_addr_o;
  logic              out_last_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output out_valid_o, out_data_o, out_addr_o, out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  out_valid_o, out_data_o, out_addr_o, out_last_o,
    output out_ready_i
  );
endinterface

// File: rtl/mem_range_stream_reader.sv
// Sweeps the inclusive range [base, end] over a req/gnt/rvalid memory port with up
// to MAX_OUTSTANDING reads in flight and returns the elements in order on a
// valid/ready stream.
// Optional feature macro: MEM_RANGE_READER_GUARD_CHECK_EN adds guard_err_o, which
// checks that the last two elements carry the guard words.
// Ports:
//   clk_i, rst_i (sync, active high)
//   start_i, base_addr_i, end_addr_i, size_i   sweep command (sampled on start)
//   bus (master)                               memory port + output stream
//   busy_o, done_o, err_o, count_o             status
//   guard_err_o                                guard mismatch (macro only)
module mem_range_stream_reader #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [ADDR_W-1:0]         end_addr_i,
  input  logic [1:0]                size_i,
  mem_range_stream_reader_if.master bus,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
`ifdef MEM_RANGE_READER_GUARD_CHECK_EN
  output logic                      guard_err_o,
`endif
  output logic [CNT_W-1:0]          count_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ERROR} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } entry_t;

  function automatic logic [ADDR_W-1:0] stride_of(input logic [1:0] s);
    case (s)
      2'd0:    return ADDR_W'(2);
      2'd1:    return ADDR_W'(4);
      default: return ADDR_W'(8);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mask_of(input logic [1:0] s);
    case (s)
      2'd0:    return DATA_W'(64'hFFFF);
      2'd1:    return DATA_W'(64'hFFFF_FFFF);
      default: return DATA_W'(64'hFFFF_FFFF_FFFF_FFFF);
    endcase
  endfunction

  state_t            state_q, state_n;
  logic [1:0]        size_q, size_n;
  logic [ADDR_W-1:0] end_q, end_n;
  logic [ADDR_W-1:0] req_addr_q, req_addr_n;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_n;
  logic              req_q, req_n;
  logic [OCC_W-1:0]  out_cnt_q, out_cnt_n;
  logic [OCC_W-1:0]  occ_q, occ_n;
  logic              valid_q, valid_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  entry_t            fifo_q [MAX_OUTSTANDING];

  logic              start_ok_c, legal_c, active_c, gnt_fire_c, last_gnt_c;
  logic              rsp_c, rsp_err_c, push_c, pop_c;
  logic [ADDR_W-1:0] amask_c;
  logic [OCC_W:0]    credit_c;
  logic [PTR_W-1:0]  wr_idx_c;
  entry_t            push_entry_c;

  // Next-state, counters and registered-output values
  always_comb begin
    state_n      = state_q;
    size_n       = size_q;
    end_n        = end_q;
    req_addr_n   = req_addr_q;
    rsp_addr_n   = rsp_addr_q;
    out_cnt_n    = out_cnt_q;
    occ_n        = occ_q;
    count_n      = count_q;
    err_n        = err_q;
    req_n        = 1'b0;

    start_ok_c   = start_i && (state_q == S_IDLE);
    amask_c      = stride_of(size_i) - ADDR_W'(1);
    legal_c      = (size_i != 2'd3) && ((base_addr_i & amask_c) == '0) &&
                   ((end_addr_i & amask_c) == '0) && (end_addr_i >= base_addr_i);
    active_c     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    gnt_fire_c   = req_q && bus.mem_gnt_i;
    last_gnt_c   = gnt_fire_c && (req_addr_q == end_q);
    // Responses are only tracked against our own outstanding reads
    rsp_c        = bus.mem_rvalid_i && (out_cnt_q != '0);
    rsp_err_c    = rsp_c && bus.mem_err_i && active_c;
    push_c       = rsp_c && !bus.mem_err_i && active_c;
    pop_c        = valid_q && bus.out_ready_i;
    wr_idx_c     = pop_c ? PTR_W'(occ_q - OCC_W'(1)) : PTR_W'(occ_q);

    push_entry_c.data = bus.mem_rdata_i & mask_of(size_q);
    push_entry_c.addr = rsp_addr_q;
    push_entry_c.last = (rsp_addr_q == end_q);

    case ({gnt_fire_c, rsp_c})
      2'b10:   out_cnt_n = out_cnt_q + OCC_W'(1);
      2'b01:   out_cnt_n = out_cnt_q - OCC_W'(1);
      default: out_cnt_n = out_cnt_q;
    endcase

    if (rsp_err_c) begin
      occ_n = '0;
    end else begin
      case ({push_c, pop_c})
        2'b10:   occ_n = occ_q + OCC_W'(1);
        2'b01:   occ_n = occ_q - OCC_W'(1);
        default: occ_n = occ_q;
      endcase
    end

    if (start_ok_c) begin
      size_n     = size_i;
      end_n      = end_addr_i;
      req_addr_n = base_addr_i;
      rsp_addr_n = base_addr_i;
      count_n    = '0;
      err_n      = 1'b0;
    end else begin
      // The end address is never incremented, so a sweep ending at the top cannot wrap
      if (gnt_fire_c && !last_gnt_c) req_addr_n = req_addr_q + stride_of(size_q);
      if (push_c) rsp_addr_n = rsp_addr_q + stride_of(size_q);
      if (pop_c) count_n = count_q + CNT_W'(1);
    end

    if (rsp_err_c || (state_q == S_ERROR)) err_n = 1'b1;

    case (state_q)
      S_IDLE:  if (start_i) state_n = legal_c ? S_ISSUE : S_ERROR;
      S_ISSUE: if (rsp_err_c) state_n = S_ERROR;
               else if (last_gnt_c) state_n = S_DRAIN;
      S_DRAIN: if (rsp_err_c) state_n = S_ERROR;
               else if (pop_c && fifo_q[0].last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      S_ERROR: if (out_cnt_q == '0) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Credit: in-flight reads plus buffered elements never exceed the FIFO depth
    credit_c = {1'b0, out_cnt_n} + {1'b0, occ_n};
    if ((state_n == S_ISSUE) && !last_gnt_c && (credit_c < (OCC_W + 1)'(MAX_OUTSTANDING)))
      req_n = 1'b1;

    valid_n = (occ_n != '0);
    done_n  = (state_n == S_DONE);
    busy_n  = (state_n == S_ISSUE) || (state_n == S_DRAIN) ||
              ((state_n == S_ERROR) && (out_cnt_n != '0));
  end

  // Control and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      end_q      <= '0;
      req_addr_q <= '0;
      rsp_addr_q <= '0;
      req_q      <= 1'b0;
      out_cnt_q  <= '0;
      occ_q      <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      size_q     <= size_n;
      end_q      <= end_n;
      req_addr_q <= req_addr_n;
      rsp_addr_q <= rsp_addr_n;
      req_q      <= req_n;
      out_cnt_q  <= out_cnt_n;
      occ_q      <= occ_n;
      valid_q    <= valid_n;
      count_q    <= count_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  // Shift FIFO: head always sits in entry 0 so the stream outputs come straight from flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else if (!rsp_err_c) begin
      if (pop_c) begin
        for (int i = 0; i + 1 < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= fifo_q[i+1];
      end
      if (push_c) fifo_q[wr_idx_c] <= push_entry_c;
    end
  end

`ifdef MEM_RANGE_READER_GUARD_CHECK_EN
  logic        guard_q;
  logic [31:0] prev_lo_q;

  // Guard words checked on the final pop; count_q == 0 there means a 1-element range
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      guard_q   <= 1'b0;
      prev_lo_q <= '0;
    end else if (start_ok_c) begin
      guard_q   <= 1'b0;
    end else if (pop_c) begin
      prev_lo_q <= fifo_q[0].data[31:0];
      if (fifo_q[0].last && ((count_q == '0) || (prev_lo_q != 32'hCADE_BABA) ||
                             (fifo_q[0].data[31:0] != 32'hACDC_FACE)))
        guard_q <= 1'b1;
    end
  end

  assign guard_err_o = guard_q;
`endif

  assign bus.mem_req_o   = req_q;
  assign bus.mem_addr_o  = req_addr_q;
  assign bus.out_valid_o = valid_q;
  assign bus.out_data_o  = fifo_q[0].data;
  assign bus.out_addr_o  = fifo_q[0].addr;
  assign bus.out_last_o  = fifo_q[0].last;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign count_o         = count_q;

endmodule

// File: tb/tb_mem_range_stream_reader.sv
// Directed bench for mem_range_stream_reader: a negedge-driven memory model with
// configurable latency, grant stalls and error injection, plus a stream sink.
module tb_mem_range_stream_reader;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] end_addr;
  logic [1:0]    size;
  logic          busy_o, done_o, err_o;
  logic [15:0]   count_o;
`ifdef MEM_RANGE_READER_GUARD_CHECK_EN
  logic          guard_err_o;
`endif

  always #5 clk = ~clk;

  mem_range_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_range_stream_reader #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4), .CNT_W(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .base_addr_i(base_addr),
    .end_addr_i(end_addr),
    .size_i(size),
    .bus(bus),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
`ifdef MEM_RANGE_READER_GUARD_CHECK_EN
    .guard_err_o(guard_err_o),
`endif
    .count_o(count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment configuration
  int lat        = 1;
  int ready_mode = 0;
  int gnt_mode   = 0;
  int err_at     = -1;
  bit hold_check = 0;
  bit ovr_en     = 0;
  logic [AW-1:0] ovr_a, ovr_b;
  logic [DW-1:0] ovr_da, ovr_db;

  // Observations
  pend_t         pend[$];
  logic [AW-1:0] req_log[$];
  logic [AW-1:0] rx_addr[$];
  logic [DW-1:0] rx_data[$];
  bit            rx_last[$];
  int            max_inflight = 0;
  int            hold_viol    = 0;
  int            rsp_idx      = 0;
  int            done_cnt     = 0;
  int            cyc          = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (ovr_en && a == ovr_a) return ovr_da;
    if (ovr_en && a == ovr_b) return ovr_db;
    return {a ^ 32'hA5A5_0000, a + 32'h1111_0000};
  endfunction

  function automatic logic [DW-1:0] exp_elem(input logic [AW-1:0] a, input logic [1:0] s);
    logic [DW-1:0] w;
    w = mem_word(a);
    case (s)
      2'd0:    return {48'h0, w[15:0]};
      2'd1:    return {32'h0, w[31:0]};
      default: return w;
    endcase
  endfunction

  // Memory model and stream sink, all driven on the falling edge
  initial begin
    pend_t p;
    bit    prev_stall;
    logic [AW-1:0] prev_addr;
    prev_stall = 0;
    prev_addr  = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_err_i    = 1'b0;
    bus.out_ready_i  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'b0;
      bus.mem_rdata_i  = '0;
      if (rst_i) begin
        pend.delete();
        bus.mem_gnt_i   = 1'b0;
        bus.out_ready_i = 1'b0;
        prev_stall      = 0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mem_word(p.addr);
          bus.mem_err_i    = (rsp_idx == err_at);
          rsp_idx++;
        end
        bus.mem_gnt_i = (gnt_mode == 0) ? 1'b1 : (cyc % 2 == 0);
        if (hold_check && prev_stall && (!bus.mem_req_o || bus.mem_addr_o != prev_addr))
          hold_viol++;
        prev_stall = bus.mem_req_o && !bus.mem_gnt_i;
        prev_addr  = bus.mem_addr_o;
        if (bus.mem_req_o && bus.mem_gnt_i) begin
          p.addr = bus.mem_addr_o;
          p.due  = cyc + lat;
          pend.push_back(p);
          req_log.push_back(bus.mem_addr_o);
        end
        if (pend.size() > max_inflight) max_inflight = pend.size();
        bus.out_ready_i = (ready_mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
        if (bus.out_valid_o && bus.out_ready_i) begin
          rx_addr.push_back(bus.out_addr_o);
          rx_data.push_back(bus.out_data_o);
          rx_last.push_back(bus.out_last_o);
        end
        if (done_o) done_cnt++;
      end
    end
  end

  task automatic run_sweep(input logic [AW-1:0] b, input logic [AW-1:0] e, input logic [1:0] s,
                           output bit timeout, output bit first_req, output logic [AW-1:0] first_addr);
    rx_addr.delete();
    rx_data.delete();
    rx_last.delete();
    req_log.delete();
    max_inflight = 0;
    hold_viol    = 0;
    rsp_idx      = 0;
    done_cnt     = 0;
    @(negedge clk);
    start_i = 1'b1; base_addr = b; end_addr = e; size = s;
    @(negedge clk);
    start_i = 1'b0;
    first_req  = bus.mem_req_o;
    first_addr = bus.mem_addr_o;
    timeout = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy_o && (done_o || err_o)) begin
        timeout = 0;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; base_addr = '0; end_addr = '0; size = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.mem_req_o); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid_o); end
    n_checks++; if (bus.out_data_o !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.out_data_o); end
    n_checks++; if ({busy_o, done_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b want 000", {busy_o, done_o, err_o}); end
    n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
`ifdef MEM_RANGE_READER_GUARD_CHECK_EN
    n_checks++; if (guard_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_guard got %b want 0", guard_err_o); end
`endif
    rst_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.mem_req_o, bus.out_last_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle got %b want 000", {bus.mem_req_o, bus.out_last_o, busy_o}); end
  endtask

  task automatic test_basic();
    bit to, fr;
    logic [AW-1:0] fa;
    lat = 1; ready_mode = 0; gnt_mode = 0; err_at = -1; hold_check = 0;
    run_sweep(32'h1000, 32'h11B0, 2'd1, to, fr, fa);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", to); end
    n_checks++; if (fr !== 1'b1 || fa !== 32'h1000) begin n_fail++; $display("FAIL basic_first_req got %b/%h want 1/00001000", fr, fa); end
    n_checks++; if (rx_addr.size() != 109) begin n_fail++; $display("FAIL basic_elems got %0d want 109", rx_addr.size()); end
    for (int i = 0; i < rx_addr.size() && i < 109; i++) begin
      logic [AW-1:0] ea;
      ea = 32'h1000 + 32'(4 * i);
      n_checks++;
      if (rx_addr[i] !== ea || rx_data[i] !== exp_elem(ea, 2'd1) || rx_last[i] !== (i == 108)) begin
        n_fail++;
        $display("FAIL basic_elem[%0d] got %h/%h/%b want %h/%h/%b", i, rx_addr[i], rx_data[i], rx_last[i], ea, exp_elem(ea, 2'd1), (i == 108));
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    n_checks++; if (count_o !== 16'd109) begin n_fail++; $display("FAIL basic_count got %0d want 109", count_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", err_o); end
  endtask

  task automatic test_backpressure();
    bit to, fr;
    logic [AW-1:0] fa;
    int bad;
    lat = 5; ready_mode = 1; gnt_mode = 1; err_at = -1; hold_check = 1;
    run_sweep(32'h1000, 32'h11B0, 2'd1, to, fr, fa);
    hold_check = 0;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b want 0", to); end
    n_checks++; if (max_inflight > 4) begin n_fail++; $display("FAIL bp_inflight got %0d want <=4", max_inflight); end
    n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL bp_req_hold got %0d want 0", hold_viol); end
    n_checks++; if (rx_addr.size() != 109) begin n_fail++; $display("FAIL bp_elems got %0d want 109", rx_addr.size()); end
    bad = 0;
    for (int i = 0; i < rx_addr.size() && i < 109; i++) begin
      if (rx_addr[i] !== 32'h1000 + 32'(4 * i) || rx_data[i] !== exp_elem(32'h1000 + 32'(4 * i), 2'd1)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_order got %0d bad want 0", bad); end
    n_checks++; if (done_cnt != 1 || count_o !== 16'd109) begin n_fail++; $display("FAIL bp_done_count got %0d/%0d want 1/109", done_cnt, count_o); end
  endtask

  task automatic test_error();
    bit to, fr;
    logic [AW-1:0] fa;
    lat = 1; ready_mode = 0; gnt_mode = 0; err_at = 2; hold_check = 0;
    run_sweep(32'h2000, 32'h203C, 2'd1, to, fr, fa);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL err_timeout got %b want 0", to); end
    n_checks++; if (rx_addr.size() != 2) begin n_fail++; $display("FAIL err_elems got %0d want 2", rx_addr.size()); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err_o); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL err_no_done got %0d want 0", done_cnt); end
    n_checks++; if (busy_o !== 1'b0 || count_o !== 16'd2) begin n_fail++; $display("FAIL err_idle got %b/%0d want 0/2", busy_o, count_o); end
    err_at = -1;
    run_sweep(32'h2000, 32'h2004, 2'd1, to, fr, fa);
    n_checks++; if (err_o !== 1'b0 || done_cnt != 1 || rx_addr.size() != 2) begin n_fail++; $display("FAIL err_clear got %b/%0d/%0d want 0/1/2", err_o, done_cnt, rx_addr.size()); end
  endtask

  task automatic test_illegal();
    logic [AW-1:0] bases [3];
    logic [AW-1:0] ends  [3];
    logic [1:0]    sizes [3];
    bases[0] = 32'h1002; ends[0] = 32'h1010; sizes[0] = 2'd1;
    bases[1] = 32'h2000; ends[1] = 32'h1FF0; sizes[1] = 2'd1;
    bases[2] = 32'h1000; ends[2] = 32'h1010; sizes[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      req_log.delete();
      done_cnt = 0;
      @(negedge clk);
      start_i = 1'b1; base_addr = bases[k]; end_addr = ends[k]; size = sizes[k];
      @(negedge clk);
      start_i = 1'b0;
      n_checks++; if (err_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL ill%0d_cycle1 got err=%b req=%b want 0/0", k, err_o, bus.mem_req_o); end
      @(negedge clk);
      n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ill%0d_err got %b want 1", k, err_o); end
      repeat (3) @(negedge clk);
      n_checks++; if (req_log.size() != 0 || done_cnt != 0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL ill%0d_quiet got reqs=%0d done=%0d busy=%b want 0/0/0", k, req_log.size(), done_cnt, busy_o); end
    end
  endtask

  task automatic test_top_of_memory();
    bit to, fr;
    logic [AW-1:0] fa;
    lat = 1; ready_mode = 0; gnt_mode = 0; err_at = -1;
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFF8, 2'd2, to, fr, fa);
    repeat (5) @(negedge clk);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL top_timeout got %b want 0", to); end
    n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL top_reqs got %0d want 2", req_log.size()); end
    if (req_log.size() == 2) begin
      n_checks++; if (req_log[0] !== 32'hFFFF_FFF0 || req_log[1] !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL top_req_addr got %h/%h want fffffff0/fffffff8", req_log[0], req_log[1]); end
    end
    n_checks++; if (rx_addr.size() != 2) begin n_fail++; $display("FAIL top_elems got %0d want 2", rx_addr.size()); end
    if (rx_addr.size() == 2) begin
      n_checks++; if (rx_data[1] !== 64'h5A5A_FFF8_1110_FFF8 || rx_last[1] !== 1'b1 || rx_last[0] !== 1'b0) begin n_fail++; $display("FAIL top_last got %h/%b want 5a5afff81110fff8/1", rx_data[1], rx_last[1]); end
    end
    n_checks++; if (done_cnt != 1 || count_o !== 16'd2) begin n_fail++; $display("FAIL top_done got %0d/%0d want 1/2", done_cnt, count_o); end
  endtask

`ifdef MEM_RANGE_READER_GUARD_CHECK_EN
  task automatic test_guard();
    bit to, fr;
    logic [AW-1:0] fa;
    lat = 1; ready_mode = 0; gnt_mode = 0; err_at = -1;
    ovr_en = 1; ovr_a = 32'h3010; ovr_b = 32'h3018;
    ovr_da = 64'h1234_5678_CADE_BABA; ovr_db = 64'h0000_0001_ACDC_FACE;
    run_sweep(32'h3000, 32'h3018, 2'd2, to, fr, fa);
    n_checks++; if (guard_err_o !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL guard_ok got %b/%0d want 0/1", guard_err_o, done_cnt); end
    n_checks++; if (rx_data.size() == 4 && rx_data[3] !== 64'h0000_0001_ACDC_FACE) begin n_fail++; $display("FAIL guard_stream got %h want 00000001acdcface", rx_data[3]); end
    ovr_db = 64'h0;
    run_sweep(32'h3000, 32'h3018, 2'd2, to, fr, fa);
    n_checks++; if (guard_err_o !== 1'b1) begin n_fail++; $display("FAIL guard_corrupt got %b want 1", guard_err_o); end
    ovr_db = 64'h0000_0001_ACDC_FACE;
    run_sweep(32'h3018, 32'h3018, 2'd2, to, fr, fa);
    n_checks++; if (guard_err_o !== 1'b1) begin n_fail++; $display("FAIL guard_short got %b want 1", guard_err_o); end
    ovr_en = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_illegal();
    test_top_of_memory();
`ifdef MEM_RANGE_READER_GUARD_CHECK_EN
    test_guard();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
